// File: rtl/xkcd_skein_seq_pkg.sv
// Shared definitions for the program sequencer feeding xkcd_skein_processor:
// program word layout, sequencer opcodes, FSM state encoding.
package xkcd_skein_seq_pkg;

    localparam int WORD_W    = 24;
    localparam int OPC_HI    = 23;
    localparam int OPC_LO    = 21;
    localparam int PAYLOAD_W = 21;
    localparam int LOOP_W    = 16;

    localparam logic [2:0] OPC_EXEC       = 3'd0;
    localparam logic [2:0] OPC_JUMP       = 3'd1;
    localparam logic [2:0] OPC_SETLOOP    = 3'd2;
    localparam logic [2:0] OPC_DJNZ       = 3'd3;
    localparam logic [2:0] OPC_WAIT_READY = 3'd4;
    localparam logic [2:0] OPC_HALT       = 3'd5;

    // Global cmd 000, no register write, no output enable.
    localparam logic [PAYLOAD_W-1:0] NOP_INSTR = 21'h000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Fetches program words from a synchronous ROM and issues processor
// instructions, adding jumps, one hardware loop counter, wait-for-ready and halt.
module instruction_sequencer
    import xkcd_skein_seq_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int ENTRY_ADDR = 0,
    parameter int INSTR_W    = 21
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               ready_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [WORD_W-1:0]  rom_data_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        exec_count_o
);

    localparam logic [ADDR_W-1:0] ENTRY_PC = ADDR_W'(ENTRY_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    seq_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 done_q, done_d;
    logic [31:0]          exec_count_q, exec_count_d;

    logic [2:0]           opcode_s;
    logic [PAYLOAD_W-1:0] payload_s;
    logic [ADDR_W-1:0]    target_s;
    logic [LOOP_W-1:0]    count_s;

    assign opcode_s  = rom_data_i[OPC_HI:OPC_LO];
    assign payload_s = rom_data_i[PAYLOAD_W-1:0];
    assign target_s  = payload_s[ADDR_W-1:0];
    assign count_s   = payload_s[LOOP_W-1:0];

    // Next-state and datapath decode; rom_data_i holds the word at pc-1 while in RUN.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        loop_cnt_d   = loop_cnt_q;
        instr_d      = INSTR_W'(NOP_INSTR);
        done_d       = 1'b0;
        exec_count_d = exec_count_q;

        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d      = ST_PRIME;
                        pc_d         = ENTRY_PC;
                        exec_count_d = 32'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    case (opcode_s)
                        OPC_EXEC: begin
                            instr_d      = payload_s[INSTR_W-1:0];
                            pc_d         = pc_q + PC_ONE;
                            exec_count_d = sat_inc32(exec_count_q);
                        end
                        OPC_JUMP: begin
                            pc_d    = target_s;
                            state_d = ST_PRIME;
                        end
                        OPC_SETLOOP: begin
                            loop_cnt_d = count_s;
                            pc_d       = pc_q + PC_ONE;
                        end
                        OPC_DJNZ: begin
                            if (loop_cnt_q > 16'd1) begin
                                loop_cnt_d = loop_cnt_q - 16'd1;
                                pc_d       = target_s;
                                state_d    = ST_PRIME;
                            end else begin
                                loop_cnt_d = 16'd0;
                                pc_d       = pc_q + PC_ONE;
                            end
                        end
                        OPC_WAIT_READY: begin
                            // pc already points past this word, so holding it resumes correctly.
                            if (ready_i) begin
                                pc_d = pc_q + PC_ONE;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                        OPC_HALT: begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            // Reserved opcodes behave as an EXEC of the all-zero NOP word.
                            pc_d         = pc_q + PC_ONE;
                            exec_count_d = sat_inc32(exec_count_q);
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (ready_i) begin
                        state_d = ST_PRIME;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            loop_cnt_q   <= 16'd0;
            instr_q      <= '0;
            done_q       <= 1'b0;
            exec_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            loop_cnt_q   <= loop_cnt_d;
            instr_q      <= instr_d;
            done_q       <= done_d;
            exec_count_q <= exec_count_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instruction_o = instr_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign exec_count_o  = exec_count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: a timed program interpreter predicts issued instructions,
// done pulses and busy windows; a negedge monitor compares the DUT against them.
module tb_instruction_sequencer;

    localparam logic [7:0] ENTRY = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = 24'h0;
    logic [20:0] instruction;
    logic        busy, done;
    logic [31:0] exec_count;

    instruction_sequencer #(.ADDR_W(8), .ENTRY_ADDR(255), .INSTR_W(21)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .ready_i(ready_i), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .instruction_o(instruction), .busy_o(busy), .done_o(done),
        .exec_count_o(exec_count)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rdy [0:65535];

    typedef struct { int t; logic [20:0] v; } iss_t;
    typedef struct { int t; int unsigned cnt; } done_t;
    iss_t  iss_q[$];
    done_t done_q[$];
    int run_s = 0;
    int run_e = 0;
    int unsigned exp_count = 0;
    int unsigned m_loop = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [2:0] o, input logic [20:0] p);
        return {o, p};
    endfunction

    task automatic put(input int off, input logic [23:0] w);
        rom[8'(int'(ENTRY) + off)] = w;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd5, 21'h0);
    endtask

    // Timed interpreter: t is the edge at which the current word is decoded.
    task automatic model_run(input int s, input int stop_edge);
        int t = s + 2;
        logic [7:0] pc = ENTRY;
        int unsigned n = 0;
        int steps = 0;
        bit fin = 1'b0;
        logic [23:0] w;
        while (!fin && steps < 5000) begin
            if (stop_edge >= 0 && t >= stop_edge) break;
            w = rom[pc];
            steps++;
            case (w[23:21])
                3'd0: begin iss_q.push_back('{t, w[20:0]}); n++; pc++; t += 1; end
                3'd1: begin pc = w[7:0]; t += 2; end
                3'd2: begin m_loop = int'(w[15:0]); pc++; t += 1; end
                3'd3: begin
                    if (m_loop > 1) begin m_loop--; pc = w[7:0]; t += 2; end
                    else begin m_loop = 0; pc++; t += 1; end
                end
                3'd4: begin
                    if (rdy[t]) begin pc++; t += 1; end
                    else begin
                        int wv = t + 1;
                        while (!rdy[wv] && wv < 65000) wv++;
                        pc++;
                        t = wv + 2;
                    end
                end
                3'd5: begin
                    if (stop_edge < 0 || t < stop_edge) done_q.push_back('{t, n});
                    fin = 1'b1;
                end
                default: begin n++; pc++; t += 1; end
            endcase
        end
        run_s = s;
        run_e = fin ? t : ((stop_edge >= 0) ? stop_edge : s);
        exp_count = n;
    endtask

    // Monitor: compares every cycle against the scoreboard, away from the clock edge.
    always @(negedge clk) begin
        if (rst_i) begin
            chk("busy", 64'(busy), 64'((cyc >= run_s && cyc < run_e) ? 1 : 0));
            while (iss_q.size() > 0 && iss_q[0].t < cyc) begin
                checks++; errors++;
                $display("FAIL missed_issue @cyc %0d: got nothing expected %0h at cyc %0d", cyc, iss_q[0].v, iss_q[0].t);
                void'(iss_q.pop_front());
            end
            if (iss_q.size() > 0 && iss_q[0].t == cyc) begin
                chk("instr", 64'(instruction), 64'(iss_q[0].v));
                void'(iss_q.pop_front());
            end else begin
                chk("instr_nop", 64'(instruction), 64'd0);
            end
            while (done_q.size() > 0 && done_q[0].t < cyc) begin
                checks++; errors++;
                $display("FAIL missed_done @cyc %0d: got nothing expected done at cyc %0d", cyc, done_q[0].t);
                void'(done_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0].t == cyc) begin
                chk("done", 64'(done), 64'd1);
                chk("exec_count_at_done", 64'(exec_count), 64'(done_q[0].cnt));
                void'(done_q.pop_front());
            end else begin
                chk("done_quiet", 64'(done), 64'd0);
            end
        end
    end

    // ready_i follows the schedule, indexed by the edge that samples it.
    initial begin
        forever begin
            @(posedge clk);
            #1 ready_i = rdy[cyc + 1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input int stop_after, input bit busy_pulse);
        int s = cyc + 1;
        int stop_edge = (stop_after >= 0) ? s + stop_after : -1;
        model_run(s, stop_edge);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (cyc < run_e + 3) begin
            stop_i  = (stop_edge >= 0 && cyc + 1 == stop_edge);
            start_i = (busy_pulse && cyc + 1 == s + 3 && s + 3 < run_e);
            tick();
        end
        stop_i  = 1'b0;
        start_i = 1'b0;
        chk("iss_queue_drained", 64'(iss_q.size()), 64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);
        chk("exec_count_final", 64'(exec_count), 64'(exp_count));
    endtask

    task automatic gen_random();
        int off = 0;
        clear_rom();
        for (int b = 0; b < int'($urandom_range(2, 6)); b++) begin
            case ($urandom_range(0, 3))
                0: for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    put(off, mk(3'd0, 21'($urandom_range(1, 21'h1FFFFF)))); off++;
                end
                1: begin
                    int body;
                    put(off, mk(3'd2, 21'($urandom_range(0, 4)))); off++;
                    body = off;
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                        put(off, mk(3'd0, 21'($urandom_range(1, 21'h1FFFFF)))); off++;
                    end
                    put(off, mk(3'd3, 21'(8'(int'(ENTRY) + body)))); off++;
                end
                2: begin
                    int k = int'($urandom_range(0, 3));
                    put(off, mk(3'd1, 21'(8'(int'(ENTRY) + off + 1 + k)))); off++;
                    for (int i = 0; i < k; i++) begin
                        put(off, mk(3'd0, 21'($urandom_range(1, 21'h1FFFFF)))); off++;
                    end
                end
                default: begin put(off, mk(3'd4, 21'h0)); off++; end
            endcase
        end
        put(off, mk(3'd5, 21'h0));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rdy[i] = 1'b1;
        clear_rom();
        repeat (3) tick();
        chk("reset_instr", 64'(instruction), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_exec_count", 64'(exec_count), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        rst_i = 1'b1;
        repeat (2) tick();

        // Two EXECs then HALT.
        clear_rom();
        put(0, mk(3'd0, 21'h00010)); put(1, mk(3'd0, 21'h00020)); put(2, mk(3'd5, 21'h0));
        run_prog(-1, 1'b0);

        // Hardware loop of three iterations.
        clear_rom();
        put(0, mk(3'd2, 21'd3)); put(1, mk(3'd0, 21'h00001));
        put(2, mk(3'd3, 21'(8'(int'(ENTRY) + 1)))); put(3, mk(3'd5, 21'h0));
        run_prog(-1, 1'b0);

        // SETLOOP 1 and 0: DJNZ falls through.
        clear_rom();
        put(0, mk(3'd2, 21'd1)); put(1, mk(3'd0, 21'h00003));
        put(2, mk(3'd3, 21'(8'(int'(ENTRY) + 1)))); put(3, mk(3'd2, 21'd0));
        put(4, mk(3'd3, 21'(8'(int'(ENTRY) + 1)))); put(5, mk(3'd5, 21'h0));
        run_prog(-1, 1'b0);

        // WAIT_READY with ready low for a stretch.
        clear_rom();
        put(0, mk(3'd4, 21'h0)); put(1, mk(3'd0, 21'h1F0000)); put(2, mk(3'd5, 21'h0));
        for (int j = 0; j < 12; j++) rdy[cyc + 1 + j] = 1'b0;
        run_prog(-1, 1'b0);

        // Endless jump loop aborted by stop.
        clear_rom();
        rom[ENTRY] = mk(3'd1, 21'h80);
        rom[8'h80] = mk(3'd0, 21'h00005);
        rom[8'h81] = mk(3'd1, 21'h80);
        run_prog(20, 1'b0);

        // Wrap from 0xFF to 0x00, start pulsed while busy.
        clear_rom();
        put(0, mk(3'd0, 21'h00007)); put(1, mk(3'd5, 21'h0));
        run_prog(-1, 1'b1);

        // Asynchronous reset in the middle of a long loop.
        clear_rom();
        put(0, mk(3'd2, 21'd50)); put(1, mk(3'd0, 21'h00009));
        put(2, mk(3'd3, 21'(8'(int'(ENTRY) + 1)))); put(3, mk(3'd5, 21'h0));
        model_run(cyc + 1, -1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (20) tick();
        #2;
        rst_i = 1'b0;
        iss_q.delete(); done_q.delete();
        run_s = 0; run_e = 0; m_loop = 0;
        #1;
        chk("async_rst_instr", 64'(instruction), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_exec_count", 64'(exec_count), 64'd0);
        chk("async_rst_rom_addr", 64'(rom_addr), 64'd0);
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        chk("post_rst_exec_count", 64'(exec_count), 64'd0);
        run_prog(-1, 1'b0);

        // Randomized programs and ready schedules, some aborted by stop.
        for (int r = 0; r < 30; r++) begin
            gen_random();
            for (int j = cyc; j < cyc + 1500; j++) rdy[j] = ($urandom_range(0, 3) != 0);
            run_prog(($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 30)) : -1,
                     1'(($urandom_range(0, 1))));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
